// File: rtl/mem_responder.sv
// mem_responder: fixed-latency 512x32 word memory with a four-phase done handshake.
// Define MEM_PARITY_EN to store an even-parity bit per word and flag mismatches on read.
module mem_responder #(
  parameter int LAT   = 3,
  parameter int DEPTH = 512
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Read,
  input  logic        Write,
  input  logic [8:0]  marToRam,
  input  logic [31:0] mdrToRam,
  input  logic        errInject,
  output logic [31:0] ramOut,
  output logic        memDone,
  output logic        memBusy,
  output logic        parErr
);

`ifdef MEM_PARITY_EN
  localparam int W = 33;
`else
  localparam int W = 32;
`endif

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t state, state_nx;

  logic [3:0]   cnt, cnt_nx;
  logic [8:0]   addr, op_addr;
  logic [31:0]  data, op_data;
  logic         wr, op_wr;
  logic         accept;
  logic         enter_ack;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] wword, rword;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (Read || Write) begin
          accept = 1'b1;
          if (LAT == 1) begin
            state_nx = ACK;
          end else begin
            state_nx = WAIT;
            cnt_nx   = 4'(LAT - 1);
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_nx = ACK;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ACK: begin
        if (!Read && !Write) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // With LAT=1 accept and commit share one edge, so bypass the latches.
  assign op_addr   = accept ? marToRam : addr;
  assign op_data   = accept ? mdrToRam : data;
  assign op_wr     = accept ? Write : wr;
  assign enter_ack = (state_nx == ACK) && (state != ACK);

  assign memDone = (state == ACK);
  assign memBusy = (state != IDLE);
  assign rword   = mem[op_addr];

`ifdef MEM_PARITY_EN
  logic inj, op_inj;

  assign op_inj = accept ? errInject : inj;
  assign wword  = {(^op_data) ^ op_inj, op_data};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      inj    <= 1'b0;
      parErr <= 1'b0;
    end else begin
      if (accept) inj <= errInject;
      if (enter_ack && !op_wr) parErr <= ^rword;
      else if (state_nx != ACK) parErr <= 1'b0;
    end
  end
`else
  logic unused_inj;

  assign unused_inj = errInject;
  assign wword      = op_data;
  assign parErr     = 1'b0;
`endif

  // Array has no reset; an aborted write never reaches the commit edge.
  always_ff @(posedge Clock) begin
    if (Reset && enter_ack && op_wr) mem[op_addr] <= wword;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      addr   <= '0;
      data   <= '0;
      wr     <= 1'b0;
      ramOut <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        addr <= marToRam;
        data <= mdrToRam;
        wr   <= Write;
      end
      if (enter_ack && !op_wr) ramOut <= rword[31:0];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: random and directed transactions against a transaction-level model.
// Covers MEM_PARITY_EN scenarios when that macro is defined.
module tb_mem_responder;
  localparam int LAT = 3;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Read = 1'b0, Write = 1'b0, errInject = 1'b0;
  logic [8:0]  marToRam = '0;
  logic [31:0] mdrToRam = '0;
  logic [31:0] ramOut;
  logic        memDone, memBusy, parErr;

  logic        Read1 = 1'b0, Write1 = 1'b0;
  logic [8:0]  mar1 = '0;
  logic [31:0] mdr1 = '0;
  logic [31:0] ramOut1;
  logic        memDone1, memBusy1, parErr1;

  int vectors = 0;
  int miscompares = 0;
  bit en = 1'b0;

  always #5 Clock = ~Clock;

  mem_responder #(.LAT(LAT)) dut (
    .Clock(Clock), .Reset(Reset), .Read(Read), .Write(Write),
    .marToRam(marToRam), .mdrToRam(mdrToRam), .errInject(errInject),
    .ramOut(ramOut), .memDone(memDone), .memBusy(memBusy), .parErr(parErr)
  );

  mem_responder #(.LAT(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Read(Read1), .Write(Write1),
    .marToRam(mar1), .mdrToRam(mdr1), .errInject(1'b0),
    .ramOut(ramOut1), .memDone(memDone1), .memBusy(memBusy1), .parErr(parErr1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an op finishes LAT edges after the request is first seen.
  bit          m_busy = 0, m_done = 0, m_par = 0, m_known = 1;
  logic [31:0] m_ramout = '0;
  int          m_age;
  bit          m_wr, m_inj;
  logic [8:0]  m_a;
  logic [31:0] m_d;
  logic [31:0] m_mem [int];
  bit          m_bad [int];

  function automatic void finish_op();
    m_done = 1;
    if (m_wr) begin
      m_mem[int'(m_a)] = m_d;
      m_bad[int'(m_a)] = m_inj;
    end else if (m_mem.exists(int'(m_a))) begin
      m_ramout = m_mem[int'(m_a)];
      m_par    = m_bad[int'(m_a)];
      m_known  = 1;
    end else begin
      m_known = 0;
    end
  endfunction

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_busy = 0; m_done = 0; m_par = 0;
      m_ramout = '0; m_known = 1;
    end else if (!m_busy) begin
      if (Read || Write) begin
        m_busy = 1;
        m_wr   = Write;
        m_a    = marToRam;
        m_d    = mdrToRam;
`ifdef MEM_PARITY_EN
        m_inj  = errInject;
`else
        m_inj  = 0;
`endif
        m_age  = 0;
        if (LAT == 1) finish_op();
      end
    end else if (!m_done) begin
      m_age++;
      if (m_age == LAT - 1) finish_op();
    end else if (!Read && !Write) begin
      m_busy = 0; m_done = 0; m_par = 0;
    end
  end

  always @(negedge Clock) begin
    if (en && Reset) begin
      chk("memDone", 32'(memDone), 32'(m_done));
      chk("memBusy", 32'(memBusy), 32'(m_busy));
      chk("parErr", 32'(parErr), 32'(m_par));
      if (m_known) chk("ramOut", ramOut, m_ramout);
    end
  end

  task automatic txn(input bit rd, input bit wr, input logic [8:0] a,
                     input logic [31:0] d, input int hold, input bit jit,
                     output int lat, output logic [31:0] rdat, output logic par);
    @(negedge Clock);
    Read = rd; Write = wr; marToRam = a; mdrToRam = d;
    lat = 0;
    do begin
      @(negedge Clock);
      lat++;
      if (jit && !memDone) begin
        marToRam = 9'($urandom);
        mdrToRam = $urandom;
        {Read, Write} = 2'($urandom_range(1, 3));
      end
    end while (!memDone && lat < 40);
    if (!memDone) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no memDone expected memDone within 40 cycles");
    end
    rdat = ramOut;
    par  = parErr;
    repeat (hold) @(negedge Clock);
    if (hold > 0) chk("held_done", 32'(memDone), 1);
    Read = 0; Write = 0;
    @(negedge Clock);
    chk("idle_after", 32'(memBusy), 0);
  endtask

  task automatic abort_wr(input logic [8:0] a, input logic [31:0] d);
    @(negedge Clock);
    Write = 1; Read = 0; marToRam = a; mdrToRam = d;
    @(posedge Clock);
    @(posedge Clock);
    #1 Reset = 0;
    #1;
    chk("rst_done", 32'(memDone), 0);
    chk("rst_busy", 32'(memBusy), 0);
    chk("rst_ramout", ramOut, 0);
    chk("rst_par", 32'(parErr), 0);
    Write = 0;
    @(negedge Clock);
    Reset = 1;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        par;
  logic [8:0]  pool [16];

  initial begin
    repeat (3) @(negedge Clock);
    chk("reset_done", 32'(memDone), 0);
    chk("reset_busy", 32'(memBusy), 0);
    chk("reset_ramout", ramOut, 0);
    chk("reset_par", 32'(parErr), 0);
    Reset = 1;
    en = 1;

    txn(0, 1, 9'h00A, 32'hDEADBEEF, 0, 0, lat, rd, par);
    chk("wr_latency", 32'(lat), 3);
    txn(1, 0, 9'h00A, 32'h0, 0, 0, lat, rd, par);
    chk("rd_latency", 32'(lat), 3);
    chk("rd_00a", rd, 32'hDEADBEEF);
    chk("rd_00a_idle", ramOut, 32'hDEADBEEF);

    txn(1, 1, 9'h1FF, 32'h12345678, 0, 0, lat, rd, par);
    chk("both_keeps_ramout", ramOut, 32'hDEADBEEF);
    txn(1, 0, 9'h1FF, 32'h0, 0, 0, lat, rd, par);
    chk("rd_1ff", rd, 32'h12345678);

    txn(0, 1, 9'h005, 32'h0BADF00D, 0, 0, lat, rd, par);
    abort_wr(9'h005, 32'hCAFEF00D);
    txn(1, 0, 9'h005, 32'h0, 0, 0, lat, rd, par);
    chk("rd_005_after_abort", rd, 32'h0BADF00D);

    txn(1, 0, 9'h00A, 32'h0, 5, 0, lat, rd, par);
    chk("held_rd_00a", rd, 32'hDEADBEEF);

`ifdef MEM_PARITY_EN
    errInject = 1;
    txn(0, 1, 9'h020, 32'h0F0F0F0F, 0, 0, lat, rd, par);
    errInject = 0;
    txn(1, 0, 9'h020, 32'h0, 0, 0, lat, rd, par);
    chk("par_injected", 32'(par), 1);
    txn(0, 1, 9'h021, 32'h76543210, 0, 0, lat, rd, par);
    txn(1, 0, 9'h021, 32'h0, 0, 0, lat, rd, par);
    chk("par_clean", 32'(par), 0);
`endif

    for (int i = 0; i < 16; i++) begin
      pool[i] = 9'(9'h100 + 9'(i * 7));
      txn(0, 1, pool[i], $urandom, 0, 0, lat, rd, par);
    end
    for (int i = 0; i < 80; i++) begin
      int op;
      logic [8:0] a;
      op = $urandom_range(0, 9);
      a = pool[$urandom_range(0, 15)];
      errInject = 1'($urandom_range(0, 1));
      if (op == 9) abort_wr(a, $urandom);
      else if (op < 5)
        txn(1, 0, a, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat, rd, par);
      else
        txn(1, op > 7, a, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat, rd, par);
    end
    errInject = 0;

    @(negedge Clock);
    Write1 = 1; mar1 = 9'h033; mdr1 = 32'hA5A50001;
    @(negedge Clock);
    chk("lat1_wr_done", 32'(memDone1), 1);
    Write1 = 0;
    @(negedge Clock);
    chk("lat1_wr_idle", 32'(memDone1), 0);
    Read1 = 1;
    @(negedge Clock);
    chk("lat1_rd_done", 32'(memDone1), 1);
    chk("lat1_rd_data", ramOut1, 32'hA5A50001);
    chk("lat1_busy", 32'(memBusy1), 1);
    chk("lat1_par", 32'(parErr1), 0);
    Read1 = 0;
    @(negedge Clock);
    chk("lat1_rd_idle", 32'(memDone1), 0);

    en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
